// File: rtl/instr_pkg.sv
// Shared MIPS instruction field definitions for the decode queue slice.
package instr_pkg;

   localparam int INSTR_W = 32;
   localparam int OP_W    = 6;
   localparam int REG_W   = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int ADDR_W  = 26;

   localparam logic [OP_W-1:0]    OP_RTYPE  = 6'h00;
   localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0;

   typedef struct packed {
      logic [OP_W-1:0]    opcode;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [REG_W-1:0]   rd;
      logic [REG_W-1:0]   shamt;
      logic [FUNCT_W-1:0] funct;
      logic [IMM_W-1:0]   immediate;
      logic [ADDR_W-1:0]  address;
   } instr_fields_t;

endpackage

// File: rtl/instr_split.sv
// Combinational split of a 32-bit MIPS word into its fields and extended immediates.
module instr_split
   import instr_pkg::*;
(
   input  logic [INSTR_W-1:0] word,
   output instr_fields_t      fields,
   output logic [31:0]        imm_sext,
   output logic [31:0]        imm_zext
);

   always_comb begin
      fields.opcode    = word[31:26];
      fields.rs        = word[25:21];
      fields.rt        = word[20:16];
      fields.rd        = word[15:11];
      fields.shamt     = word[10:6];
      fields.funct     = word[5:0];
      fields.immediate = word[15:0];
      fields.address   = word[25:0];
      imm_sext         = {{(32-IMM_W){word[15]}}, word[15:0]};
      imm_zext         = {{(32-IMM_W){1'b0}}, word[15:0]};
   end

endmodule

// File: rtl/instr_decode_queue.sv
// Circular instruction/PC buffer presenting a pre-decoded head entry.
// Optional same-cycle pass-through when empty: define IDQ_BYPASS_EN.
module instr_decode_queue
   import instr_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_instr,
   input  logic [PC_W-1:0]           in_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PC_W-1:0]           out_pc,
   output logic [5:0]                opcode,
   output logic [4:0]                rs,
   output logic [4:0]                rt,
   output logic [4:0]                rd,
   output logic [4:0]                shamt,
   output logic [5:0]                funct,
   output logic [15:0]               immediate,
   output logic [25:0]               address,
   output logic [31:0]               imm_sext,
   output logic [31:0]               imm_zext,
   output logic                      is_rtype,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;

   logic            empty;
   logic            byp;
   logic            push;
   logic            pop;
   logic            wr_en;
   logic            rd_en;
   logic [31:0]     sel_word;
   logic [PC_W-1:0] sel_pc;
   instr_fields_t   fields;

   assign empty = (cnt == '0);

`ifdef IDQ_BYPASS_EN
   assign byp = empty & in_valid & ~flush;
`else
   assign byp = 1'b0;
`endif

   assign in_ready  = (cnt != FULL);
   assign out_valid = ~flush & (~empty | byp);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // A bypassed word consumed this cycle never touches storage.
   assign wr_en = push & ~(byp & out_ready);
   assign rd_en = pop & ~byp;

   always_comb begin
      sel_word = INSTR_NOP;
      sel_pc   = '0;
      if (out_valid) begin
         if (byp) begin
            sel_word = in_instr;
            sel_pc   = in_pc;
         end else begin
            sel_word = mem[rd_ptr].instr;
            sel_pc   = mem[rd_ptr].pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !flush && !reset) begin
         mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
      end
   end

   instr_split u_split (
      .word     (sel_word),
      .fields   (fields),
      .imm_sext (imm_sext),
      .imm_zext (imm_zext)
   );

   assign out_pc    = sel_pc;
   assign opcode    = fields.opcode;
   assign rs        = fields.rs;
   assign rt        = fields.rt;
   assign rd        = fields.rd;
   assign shamt     = fields.shamt;
   assign funct     = fields.funct;
   assign immediate = fields.immediate;
   assign address   = fields.address;
   assign is_rtype  = out_valid & (fields.opcode == OP_RTYPE);
   assign count     = cnt;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: directed table, hand sequences, random vs queue model.
module tb_instr_decode_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] immediate;
   logic [25:0] address;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
   logic        is_rtype;
   logic [2:0]  count;

   instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .immediate(immediate), .address(address),
      .imm_sext(imm_sext), .imm_zext(imm_zext), .is_rtype(is_rtype), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct {
      bit          rst;
      bit          flush;
      bit          valid;
      bit          rdy;
      logic [31:0] instr;
      logic [31:0] pc;
      bit          chk;
      logic [2:0]  ecount;
      bit          eready;
      bit          evalid;
      logic [31:0] eword;
      logic [31:0] epc;
      logic [31:0] esext;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];

   function automatic vec_t mk(bit r, bit f, bit v, bit rdy_i, logic [31:0] ins, logic [31:0] p,
                               bit c, logic [2:0] ec, bit er, bit ev, logic [31:0] ew,
                               logic [31:0] ep, logic [31:0] es);
      vec_t t;
      t.rst = r; t.flush = f; t.valid = v; t.rdy = rdy_i; t.instr = ins; t.pc = p;
      t.chk = c; t.ecount = ec; t.eready = er; t.evalid = ev; t.eword = ew; t.epc = ep;
      t.esext = es;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] w, input logic [31:0] p, input bit v);
      logic [31:0] s;
      s = 32'($signed(w[15:0]));
      chk({tag, "_opcode"}, 64'(opcode), 64'(w[31:26]));
      chk({tag, "_rs"}, 64'(rs), 64'(w[25:21]));
      chk({tag, "_rt"}, 64'(rt), 64'(w[20:16]));
      chk({tag, "_rd"}, 64'(rd), 64'(w[15:11]));
      chk({tag, "_shamt"}, 64'(shamt), 64'(w[10:6]));
      chk({tag, "_funct"}, 64'(funct), 64'(w[5:0]));
      chk({tag, "_imm"}, 64'(immediate), 64'(w[15:0]));
      chk({tag, "_addr"}, 64'(address), 64'(w[25:0]));
      chk({tag, "_sext"}, 64'(imm_sext), 64'(s));
      chk({tag, "_zext"}, 64'(imm_zext), 64'(w & 32'h0000_FFFF));
      chk({tag, "_pc"}, 64'(out_pc), 64'(p));
      chk({tag, "_rtype"}, 64'(is_rtype), 64'(v && (w[31:26] == 6'd0)));
   endtask

   // One cycle: drive, check before the edge against model (and table row), then advance model.
   task automatic step(input vec_t v, input bit use_tbl, input string tag);
      bit          byp;
      bit          ev;
      bit          pop_m;
      bit          push_m;
      bit          pass;
      logic [31:0] ew;
      logic [31:0] ep;
      reset = v.rst; flush = v.flush; in_valid = v.valid; out_ready = v.rdy;
      in_instr = v.instr; in_pc = v.pc;
      #1;
`ifdef IDQ_BYPASS_EN
      byp = (q.size() == 0) && v.valid && !v.flush;
`else
      byp = 1'b0;
`endif
      ev = !v.flush && (q.size() != 0 || byp);
      ew = 32'h0; ep = 32'h0;
      if (ev) begin
         if (q.size() != 0) begin ew = q[0].instr; ep = q[0].pc; end
         else begin ew = v.instr; ep = v.pc; end
      end
      if (v.chk) begin
         chk({tag, "_count"}, 64'(count), 64'(q.size()));
         chk({tag, "_in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
         chk({tag, "_out_valid"}, 64'(out_valid), 64'(ev));
         chk_word(tag, ew, ep, ev);
      end
      if (use_tbl && v.chk) begin
         chk({tag, "_tcount"}, 64'(count), 64'(v.ecount));
         chk({tag, "_tready"}, 64'(in_ready), 64'(v.eready));
`ifdef IDQ_BYPASS_EN
         if (!(v.ecount == 0 && v.valid && !v.flush)) begin
`else
         begin
`endif
            chk({tag, "_tvalid"}, 64'(out_valid), 64'(v.evalid));
            chk({tag, "_tword"}, 64'({opcode, rs, rt, rd, shamt, funct}), 64'(v.eword));
            chk({tag, "_tpc"}, 64'(out_pc), 64'(v.epc));
            chk({tag, "_tsext"}, 64'(imm_sext), 64'(v.esext));
         end
      end
      pop_m  = ev && v.rdy;
      push_m = v.valid && (q.size() < DEPTH);
      pass   = pop_m && (q.size() == 0);
      @(posedge clk);
      if (v.rst || v.flush) begin
         q.delete();
      end else begin
         if (pop_m && !pass) void'(q.pop_front());
         if (push_m && !pass) q.push_back('{instr: v.instr, pc: v.pc});
      end
      @(negedge clk);
   endtask

   vec_t tbl[18];
   vec_t v;

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      @(negedge clk);

      //           rst f  v  rdy instr          pc          chk cnt rdy val word           pc          sext
      tbl[0]  = mk(1, 0, 0, 0, 32'h0,        32'h0,      0, 0, 1, 0, 32'h0,        32'h0,    32'h0);
      tbl[1]  = mk(0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 0, 32'h0,        32'h0,    32'h0);
      tbl[2]  = mk(0, 0, 1, 0, 32'h2108FFFF, 32'h3000,   1, 0, 1, 0, 32'h0,        32'h0,    32'h0);
      tbl[3]  = mk(0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 1, 32'h2108FFFF, 32'h3000, 32'hFFFFFFFF);
      tbl[4]  = mk(0, 0, 1, 0, 32'h8C220004, 32'h3004,   1, 1, 1, 1, 32'h2108FFFF, 32'h3000, 32'hFFFFFFFF);
      tbl[5]  = mk(0, 0, 1, 0, 32'hAC430008, 32'h3008,   1, 2, 1, 1, 32'h2108FFFF, 32'h3000, 32'hFFFFFFFF);
      tbl[6]  = mk(0, 0, 1, 0, 32'h0043082A, 32'h300C,   1, 3, 1, 1, 32'h2108FFFF, 32'h3000, 32'hFFFFFFFF);
      tbl[7]  = mk(0, 0, 1, 0, 32'h08000010, 32'h3010,   1, 4, 0, 1, 32'h2108FFFF, 32'h3000, 32'hFFFFFFFF);
      tbl[8]  = mk(0, 0, 0, 1, 32'h0,        32'h0,      1, 4, 0, 1, 32'h2108FFFF, 32'h3000, 32'hFFFFFFFF);
      tbl[9]  = mk(0, 0, 0, 1, 32'h0,        32'h0,      1, 3, 1, 1, 32'h8C220004, 32'h3004, 32'h4);
      tbl[10] = mk(0, 0, 0, 1, 32'h0,        32'h0,      1, 2, 1, 1, 32'hAC430008, 32'h3008, 32'h8);
      tbl[11] = mk(0, 0, 0, 1, 32'h0,        32'h0,      1, 1, 1, 1, 32'h0043082A, 32'h300C, 32'h82A);
      tbl[12] = mk(0, 0, 1, 0, 32'h20A50001, 32'h3014,   1, 0, 1, 0, 32'h0,        32'h0,    32'h0);
      tbl[13] = mk(0, 0, 1, 0, 32'h20A50002, 32'h3018,   1, 1, 1, 1, 32'h20A50001, 32'h3014, 32'h1);
      tbl[14] = mk(0, 0, 1, 0, 32'h20A50003, 32'h301C,   1, 2, 1, 1, 32'h20A50001, 32'h3014, 32'h1);
      tbl[15] = mk(0, 1, 1, 1, 32'hDEADBEEF, 32'hBAD,    1, 3, 1, 0, 32'h0,        32'h0,    32'h0);
      tbl[16] = mk(0, 0, 0, 1, 32'h0,        32'h0,      1, 0, 1, 0, 32'h0,        32'h0,    32'h0);
      tbl[17] = mk(0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 0, 32'h0,        32'h0,    32'h0);

      for (int i = 0; i < 18; i++) step(tbl[i], 1'b1, $sformatf("row%0d", i));

      // Steady state at count=2 with simultaneous push and pop.
      for (int i = 0; i < 2; i++)
         step(mk(0, 0, 1, 0, 32'h24000000 | 32'(i), 32'h4000 + 32'(4 * i), 1, 0, 0, 0, 0, 0, 0),
              1'b0, "fill2");
      for (int i = 0; i < 10; i++) begin
         v = mk(0, 0, 1, 1, 32'h24000000 | 32'(i + 2), 32'h4000 + 32'(4 * (i + 2)),
                1, 0, 0, 0, 0, 0, 0);
         in_valid = 1'b1; out_ready = 1'b1; in_instr = v.instr; in_pc = v.pc;
         #1;
         chk("steady_count", 64'(count), 64'd2);
         chk("steady_pc", 64'(out_pc), 64'(32'h4000 + 32'(4 * i)));
         step(v, 1'b0, "steady");
      end
      for (int i = 0; i < 2; i++) step(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, "drain");
      chk("drained_count", 64'(count), 64'd0);

`ifdef IDQ_BYPASS_EN
      // Empty queue pass-through: visible this cycle, nothing stored.
      reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_instr = 32'h00851020; in_pc = 32'h5000;
      #1;
      chk("byp_valid", 64'(out_valid), 64'd1);
      chk("byp_funct", 64'(funct), 64'h20);
      chk("byp_rd", 64'(rd), 64'd2);
      chk("byp_rtype", 64'(is_rtype), 64'd1);
      chk("byp_pc", 64'(out_pc), 64'h5000);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("byp_count", 64'(count), 64'd0);
      chk("byp_after_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
`endif

      // Randomized traffic against the queue model.
      for (int i = 0; i < 600; i++) begin
         v = mk($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 55,
                $urandom, 32'h8000 + 32'(4 * i), 1, 0, 0, 0, 0, 0, 0);
         step(v, 1'b0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Parametrised instruction buffer with field decode for the MIPS datapath, sitting between instruction memory and the decode/control stage. Holds up to `DEPTH` fetched instruction/PC pairs in a circular queue with valid/ready handshakes on both sides, and presents the head entry already split into opcode, rs, rt, rd, shamt, funct, immediate and jump address. It also presents sign- and zero-extended immediates. Supports pipeline flush on branch/jump redirect.

## Interface
Parameters:
- `DEPTH`, 4: entry count; power of two, ≥2.
- `PC_W`, 32: width of the stored PC.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears the queue.
- `flush`  in  1  discard all entries (redirect).
- `in_valid`  in  1  upstream instruction present.
- `in_ready`  out  1  queue can accept.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  PC of `in_instr`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream consumes head.
- `out_pc`  out  PC_W  PC of head.
- `opcode` out 6 = [31:26]; `rs` out 5 = [25:21]; `rt` out 5 = [20:16]; `rd` out 5 = [15:11]; `shamt` out 5 = [10:6]; `funct` out 6 = [5:0].
- `immediate` out 16 = [15:0]; `address` out 26 = [25:0].
- `imm_sext`  out  32  `immediate` sign-extended.
- `imm_zext`  out  32  `immediate` zero-extended.
- `is_rtype`  out  1  `opcode == 6'h00` and `out_valid`.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: `DEPTH` × {instr, pc} array; `wr_ptr`, `rd_ptr` of $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` tracks occupancy 0..DEPTH.
- `push = in_valid & in_ready`. `pop = out_valid & out_ready`.
- `in_ready = (count != DEPTH)`. It depends only on registered state; a full queue refuses a push even when a pop occurs in the same cycle.
- `out_valid = (count != 0)`.
- Push writes `mem[wr_ptr]` and increments `wr_ptr`. Pop increments `rd_ptr`.
- `count` update: push only +1; pop only −1; push and pop together unchanged; neither unchanged.
- Push and pop on the same slot cannot occur because a push while full is impossible.
- Priority at the clock edge: `reset` > `flush` > push/pop.
  - `flush` zeroes `wr_ptr`, `rd_ptr` and `count`.
  - A push presented in a flush cycle is dropped.
  - A pop acknowledged in a flush cycle is the last consumer of that entry.
- Decode outputs come from the head word when `out_valid=1`. When `out_valid=0` they decode 32'h0000_0000 (NOP); all fields, `out_pc`, `imm_sext`, `imm_zext` and `is_rtype` are 0.
- Reset values: `out_valid=0`, `in_ready=1`, `count=0`, all decode outputs and `out_pc` 0.

## Timing
- Storage path latency: an instruction pushed at edge N is visible on the outputs after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- After `flush` or `reset` is asserted at edge N: `out_valid=0` and `in_ready=1` from cycle N+1.
- Decode outputs and `is_rtype` are combinational from the head register; `in_ready` and `out_valid` are direct decodes of `count`.
- `reset` mid-operation discards contents identically to `flush`.

## Configuration
- `IDQ_BYPASS_EN` defined:
  - When `count==0`, `in_valid=1` and `flush=0`, `out_valid=1` and the outputs decode `in_instr`/`in_pc` combinationally in the same cycle.
  - If `out_ready=1` in that cycle, the instruction passes through; nothing is written and `count` stays 0.
  - If `out_ready=0`, it is stored normally.
- `IDQ_BYPASS_EN` undefined: no bypass; minimum latency is 1 cycle.
- In both builds `flush=1` forces `out_valid=0` in that cycle.

## Structure
- Shared package `instr_pkg`:
  - field-width localparams (OP_W=6, REG_W=5, FUNCT_W=6, IMM_W=16, ADDR_W=26)
  - `OP_RTYPE=6'h00`
  - `INSTR_NOP=32'h0`
  - packed struct `instr_fields_t`
- Sub-module `instr_split`: purely combinational; takes a 32-bit word and produces `instr_fields_t` plus `imm_sext`/`imm_zext`. It is instantiated once on the selected head/bypass word.

## Test plan
- Reset, then idle: `out_valid=0`, `in_ready=1`, `count=0`, `opcode=0`, `imm_sext=0`.
- Push 32'h2108FFFF (addi $8,$8,-1) with pc 32'h3000, `out_ready=0`; next cycle:
  - `opcode=6'h08`, `rs=8`, `rt=8`
  - `imm_sext=32'hFFFFFFFF`, `imm_zext=32'h0000FFFF`
  - `out_pc=32'h3000`, `count=1`
- Push 5 words with `out_ready=0` at DEPTH=4: the 5th is refused (`in_ready=0` once `count=4`). Then pop 4 in order; PCs come out in ascending order and the ptrs wrap correctly.
- Hold `count=2`; simultaneous push+pop for 10 cycles: `count` stays 2 and the order is preserved.
- With `count=3`, assert `flush` together with `in_valid`: next cycle `count=0`, `out_valid=0`, and the flushed-cycle word never appears.
- `IDQ_BYPASS_EN` build: empty queue, push 32'h00851020 (add $2,$4,$5) with `out_ready=1`:
  - same cycle: `out_valid=1`, `funct=6'h20`, `rd=2`, `is_rtype=1`
  - next cycle: `count=0`
